// File: rtl/astro_pkg.sv
// Shared state encodings, default parameters and the score helper for the
// Astro Barrier game sequencer.
package astro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_CLEAR = 2'b10,
    ST_DONE  = 2'b11
  } astro_state_e;

  localparam int unsigned DEF_N_TGT           = 32'd4;
  localparam int unsigned DEF_NUM_LEVELS      = 32'd4;
  localparam int unsigned DEF_SHOTS_PER_LEVEL = 32'd6;
  localparam int unsigned DEF_CLEAR_TICKS     = 32'd32;
  localparam int unsigned DEF_SCORE_W         = 32'd8;

  // A hit is worth level+1 points; the sum saturates at the all-ones value of width bits.
  function automatic logic [31:0] score_add(input logic [31:0] score,
                                            input logic [31:0] level,
                                            input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << width) - 33'd1;
    sum = {1'b0, score} + {1'b0, level} + 33'd1;
    if (sum > max) begin
      return max[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/astro_evt_capture.sv
// Sticky capture of datapath hit/expiry pulses and the fire button rising
// edge; everything pending is dropped on the consuming game tick.
module astro_evt_capture
  import astro_pkg::*;
#(
  parameter int unsigned ID_W = 32'd2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            consume_i,
  input  logic            fire_req_i,
  input  logic            hit_valid_i,
  input  logic [ID_W-1:0] hit_id_i,
  input  logic            bullet_done_i,
  output logic            fire_pend_o,
  output logic            hit_pend_o,
  output logic [ID_W-1:0] hit_id_o,
  output logic            done_pend_o
);

  logic            fire_prev_q, fire_q, hit_q, done_q;
  logic            fire_q_d, hit_d, done_d;
  logic [ID_W-1:0] id_q, id_d;

  // Pending view includes a pulse landing on the tick cycle itself.
  always_comb begin
    fire_pend_o = fire_q | (fire_req_i & ~fire_prev_q);
    hit_pend_o  = hit_q | hit_valid_i;
    hit_id_o    = hit_valid_i ? hit_id_i : id_q;
    done_pend_o = done_q | bullet_done_i;
    id_d        = hit_id_o;
    if (consume_i) begin
      fire_q_d = 1'b0;
      hit_d    = 1'b0;
      done_d   = 1'b0;
    end else begin
      fire_q_d = fire_pend_o;
      hit_d    = hit_pend_o;
      done_d   = done_pend_o;
    end
  end

  // Flag registers and fire level history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fire_prev_q <= 1'b0;
      fire_q      <= 1'b0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      id_q        <= '0;
    end else begin
      fire_prev_q <= fire_req_i;
      fire_q      <= fire_q_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: rtl/astro_game_ctrl.sv
// Astro Barrier game sequencer: state machine, levels, shot budget, target mask
// and score. Optional shot refund on hit is enabled by ASTRO_REFUND_SHOT_EN.
module astro_game_ctrl
  import astro_pkg::*;
#(
  parameter  int unsigned N_TGT           = DEF_N_TGT,
  parameter  int unsigned NUM_LEVELS      = DEF_NUM_LEVELS,
  parameter  int unsigned SHOTS_PER_LEVEL = DEF_SHOTS_PER_LEVEL,
  parameter  int unsigned CLEAR_TICKS     = DEF_CLEAR_TICKS,
  parameter  int unsigned SCORE_W         = DEF_SCORE_W,
  localparam int unsigned ID_W            = $clog2(N_TGT),
  localparam int unsigned LVL_W           = $clog2(NUM_LEVELS),
  localparam int unsigned SHOT_W          = $clog2(SHOTS_PER_LEVEL + 1),
  localparam int unsigned CNT_W           = $clog2(CLEAR_TICKS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               start,
  input  logic               fire_req,
  input  logic               hit_valid,
  input  logic [ID_W-1:0]    hit_id,
  input  logic               bullet_done,
  output logic [1:0]         state,
  output logic [LVL_W-1:0]   level,
  output logic [SHOT_W-1:0]  shots_left,
  output logic               bullet_launch,
  output logic               in_flight,
  output logic [N_TGT-1:0]   tgt_alive,
  output logic [SCORE_W-1:0] score,
  output logic               won,
  output logic               lost
);

  astro_state_e       state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SHOT_W-1:0]  shots_q, shots_d;
  logic [N_TGT-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               infl_q, infl_d, launch_q, launch_d, won_q, won_d, lost_q, lost_d;
  logic               fire_pend_s, hit_pend_s, done_pend_s;
  logic [ID_W-1:0]    hit_id_s;

  astro_evt_capture #(.ID_W(ID_W)) u_evt (
    .clk          (clk),
    .reset_n      (reset_n),
    .consume_i    (tick),
    .fire_req_i   (fire_req),
    .hit_valid_i  (hit_valid),
    .hit_id_i     (hit_id),
    .bullet_done_i(bullet_done),
    .fire_pend_o  (fire_pend_s),
    .hit_pend_o   (hit_pend_s),
    .hit_id_o     (hit_id_s),
    .done_pend_o  (done_pend_s)
  );

  // Next-state logic; PLAY steps chain through the _d values so later steps see earlier effects.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    shots_d   = shots_q;
    alive_d   = alive_q;
    score_d   = score_q;
    clr_cnt_d = clr_cnt_q;
    infl_d    = infl_q;
    won_d     = won_q;
    lost_d    = lost_q;
    launch_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_PLAY;
            level_d = '0;
            score_d = '0;
            shots_d = SHOT_W'(SHOTS_PER_LEVEL);
            alive_d = '1;
            infl_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (hit_pend_s && infl_q && alive_q[hit_id_s]) begin
            alive_d[hit_id_s] = 1'b0;
            infl_d            = 1'b0;
            score_d           = SCORE_W'(score_add(32'(score_q), 32'(level_q), SCORE_W));
`ifdef ASTRO_REFUND_SHOT_EN
            if (shots_q < SHOT_W'(SHOTS_PER_LEVEL)) begin
              shots_d = shots_q + SHOT_W'(1);
            end else begin
              shots_d = shots_q;
            end
`else
            shots_d = shots_q;
`endif
          end else if (done_pend_s && infl_q) begin
            infl_d = 1'b0;
          end else begin
            infl_d = infl_q;
          end
          if (fire_pend_s && !infl_d && (shots_d != '0)) begin
            launch_d = 1'b1;
            infl_d   = 1'b1;
            shots_d  = shots_d - SHOT_W'(1);
          end else begin
            launch_d = 1'b0;
          end
          if (alive_d == '0) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else if ((shots_d == '0) && !infl_d) begin
            state_d = ST_DONE;
            lost_d  = 1'b1;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CNT_W'(CLEAR_TICKS - 1)) begin
            if (level_q == LVL_W'(NUM_LEVELS - 1)) begin
              state_d = ST_DONE;
              won_d   = 1'b1;
            end else begin
              state_d = ST_PLAY;
              level_d = level_q + LVL_W'(1);
              shots_d = SHOT_W'(SHOTS_PER_LEVEL);
              alive_d = '1;
            end
          end else begin
            clr_cnt_d = clr_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_d = ST_IDLE;
            won_d   = 1'b0;
            lost_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Game state registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      shots_q   <= '0;
      alive_q   <= '0;
      score_q   <= '0;
      clr_cnt_q <= '0;
      infl_q    <= 1'b0;
      launch_q  <= 1'b0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      shots_q   <= shots_d;
      alive_q   <= alive_d;
      score_q   <= score_d;
      clr_cnt_q <= clr_cnt_d;
      infl_q    <= infl_d;
      launch_q  <= launch_d;
      won_q     <= won_d;
      lost_q    <= lost_d;
    end
  end

  assign state         = state_q;
  assign level         = level_q;
  assign shots_left    = shots_q;
  assign tgt_alive     = alive_q;
  assign score         = score_q;
  assign in_flight     = infl_q;
  assign bullet_launch = launch_q;
  assign won           = won_q;
  assign lost          = lost_q;

endmodule

// File: doc/astro_game_ctrl.md
Name: astro_game_ctrl

Overview:
Game sequencer for the Astro Barrier VGA game. It owns the game state machine, level progression, the per-level shot budget, the single-bullet-in-flight rule, the target-alive mask and the score. The sprite/collision datapath runs on the game-frame tick and reports hits and bullet expiry. This block tells that datapath when to launch a bullet and which targets to draw, and drives the state LEDs and the SSD score digits.

Parameters:
N_TGT, 4, number of targets per level (alive-mask width)
NUM_LEVELS, 4, levels before win
SHOTS_PER_LEVEL, 6, shot budget loaded at each level start
CLEAR_TICKS, 32, game ticks spent in LEVEL_CLEAR banner
SCORE_W, 8, score width

Ports:
clk  in  1  system clock (divided board clock)
reset_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle game-frame enable; all game updates qualify on it except event capture
start  in  1  level from Sw1, already synchronised
fire_req  in  1  debounced btnU level
hit_valid  in  1  one-cycle pulse: bullet hit target hit_id
hit_id  in  $clog2(N_TGT)  index of hit target
bullet_done  in  1  one-cycle pulse: bullet left screen without hit
state  out  2  00 IDLE, 01 PLAY, 10 LEVEL_CLEAR, 11 DONE
level  out  $clog2(NUM_LEVELS)  current level
shots_left  out  $clog2(SHOTS_PER_LEVEL+1)  remaining shots
bullet_launch  out  1  one-cycle pulse (tick-aligned): datapath latches ship X and spawns bullet
in_flight  out  1  bullet active
tgt_alive  out  N_TGT  per-target draw enable
score  out  SCORE_W  saturating score
won  out  1  DONE with all levels cleared
lost  out  1  DONE with budget exhausted

Behaviour:
- Reset (async, reset_n=0) sets state=IDLE, level=0, shots_left=0, bullet_launch=0, in_flight=0, tgt_alive=0, score=0, won=0, lost=0. Deassertion is honoured on the next clk edge. Reset mid-game discards everything.
- hit_valid and bullet_done are captured into sticky flags on any clk. The flags are consumed on the next tick, so pulses between ticks are not lost.
- IDLE: on tick with start=1 -> PLAY. Entry loads level=0, score=0, shots_left=SHOTS_PER_LEVEL, tgt_alive=all ones.
- PLAY, evaluated per tick in priority order:
  1. Pending hit with in_flight=1 and tgt_alive[hit_id]=1: clear that bit, in_flight=0, score += level+1 (saturate at all ones). A hit on an already-dead target, or with in_flight=0, is ignored but clears the flag.
  2. Pending bullet_done with in_flight=1: in_flight=0.
  3. Fire: launch when the fire_req rising edge is sampled on the tick and in_flight=0 (after steps 1-2) and shots_left>0. Effects: bullet_launch=1 for exactly one clk (the tick cycle +1), in_flight=1, shots_left-1. Holding fire_req does not re-fire. Fire with shots_left=0 is ignored.
  4. tgt_alive==0 -> LEVEL_CLEAR. Otherwise shots_left==0 and in_flight==0 -> DONE with lost=1.
- Hit and done on the same tick: hit wins; done is discarded.
- LEVEL_CLEAR: counts CLEAR_TICKS ticks. Then, if level==NUM_LEVELS-1 -> DONE with won=1; else level+1, shots_left=SHOTS_PER_LEVEL, tgt_alive=all ones -> PLAY. Fire is ignored in this state.
- DONE: outputs held. start=0 on a tick -> IDLE, which clears won/lost; score is held until the next PLAY entry.
- Latency: an event captured before tick N is reflected in outputs at clk after tick N.

Optional Feature:
ASTRO_REFUND_SHOT_EN
- Defined: each valid hit also increments shots_left, saturating at SHOTS_PER_LEVEL, applied before the step-4 fail check.
- Undefined: shots are never refunded.

Decomposition:
- Package astro_pkg: state encodings (ST_IDLE, ST_PLAY, ST_CLEAR, ST_DONE), default parameter constants, and the score-increment function.
- One sub-module astro_evt_capture: sticky capture of hit_valid/hit_id/bullet_done plus the fire_req rising-edge detector, cleared on consume.

Test Plan:
- reset_n low mid-PLAY -> all outputs at reset values immediately. start=1 plus tick -> state=01, shots_left=6, tgt_alive=4'b1111.
- Fire edge on tick -> bullet_launch high 1 clk, in_flight=1, shots_left=5. A second edge while in flight -> no launch. Holding fire_req 10 ticks -> single launch.
- Hit pulse id=2 between ticks, in level 1 -> next tick tgt_alive=4'b1011, score +2, in_flight=0. Repeat id=2 -> ignored.
- Six misses via bullet_done -> state=11, lost=1. Kill all 4 targets -> LEVEL_CLEAR, 32 ticks, level=1, shots=6. Clearing level 3 -> won=1.
- hit_valid and bullet_done in the same tick window -> hit applied, no double decrement. With ASTRO_REFUND_SHOT_EN: a hit at shots_left=5 -> 6, never exceeds 6.
- score at 8'hFE plus a level-3 hit -> 8'hFF saturated.
